traffic_timer: RTL and testbench

Interval timer and input conditioner for the highway/farm-road traffic-light controller. It consumes the controller's registered `ST` (start-timer) pulse and returns the short/long interval flags `TS`/`TL`. It also produces the clean `C` (farm-road car present) and `Emergency` levels that the controller's state machine samples. It sits directly between the raw field inputs and the light FSM, clocked from the same `Clk`.

---
 rtl/traffic_pkg.sv | 18 +
 rtl/sensor_debounce.sv | 36 +++
 rtl/traffic_timer.sv | 82 ++++++++
 tb/tb_traffic_timer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: default timing constants and light encodings shared by the traffic-light blocks
package traffic_pkg;
    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_TS_TICKS = 3;
    localparam int DEF_TL_TICKS = 10;
    localparam int DEF_DEB_LEN  = 3;

    typedef enum logic [1:0] {
        HG = 2'd0,
        HY = 2'd1,
        FG = 2'd2,
        FY = 2'd3
    } light_t;

    function automatic int width_for(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sensor_debounce.sv
// sensor_debounce: 2-flop synchronizer followed by a DEB_LEN-sample agreement filter
module sensor_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_LEN = DEF_DEB_LEN
) (
    input  logic Clk,
    input  logic reset,
    input  logic raw,
    output logic level
);
    localparam int DW = width_for(DEB_LEN);
    localparam logic [DW-1:0] LAST = DW'(DEB_LEN - 1);

    logic [1:0]    sync;
    logic [DW-1:0] cnt;
    logic          diff;
    logic          done;

    always_comb begin
        diff = sync[1] != level;
        done = diff && cnt == LAST;
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            cnt   <= (diff && !done) ? cnt + 1'b1 : '0;
            level <= done ? sync[1] : level;
        end
    end
endmodule

// File: rtl/traffic_timer.sv
// traffic_timer: ST-aligned short/long interval flags plus conditioned car and emergency inputs
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int TS_TICKS = DEF_TS_TICKS,
    parameter int TL_TICKS = DEF_TL_TICKS,
    parameter int DEB_LEN  = DEF_DEB_LEN,
    parameter int CNT_W    = 8
) (
    input  logic Clk,
    input  logic reset,
    input  logic ST,
    input  logic CarRaw,
    input  logic EmergRaw,
    output logic TS,
    output logic TL,
    output logic C,
    output logic Emergency
);
    localparam int PW = width_for(TICK_DIV);
    localparam logic [PW-1:0]    PMAX = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] SMIN = CNT_W'(TS_TICKS);
    localparam logic [CNT_W-1:0] SMAX = CNT_W'(TL_TICKS);

    if (TICK_DIV < 1) begin : g_chk_div
        $error("TICK_DIV must be >= 1");
    end
    if (TS_TICKS < 1) begin : g_chk_ts
        $error("TS_TICKS must be >= 1");
    end
    if (TL_TICKS <= TS_TICKS) begin : g_chk_tl
        $error("TL_TICKS must exceed TS_TICKS");
    end
    if (DEB_LEN < 1) begin : g_chk_deb
        $error("DEB_LEN must be >= 1");
    end
    if (CNT_W < 31 && TL_TICKS >= (1 << CNT_W)) begin : g_chk_cnt
        $error("TL_TICKS does not fit in CNT_W bits");
    end

    logic [PW-1:0]    pre;
    logic [PW-1:0]    pre_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick;
    logic             emerg_nxt;
    logic [2:0]       esync;

    // ST restarts the prescaler too, so the first tick lands TICK_DIV cycles after ST
    always_comb begin
        tick      = pre == PMAX;
        pre_nxt   = (ST || tick) ? '0 : pre + 1'b1;
        cnt_nxt   = ST ? '0 : (tick && cnt != SMAX) ? cnt + 1'b1 : cnt;
        emerg_nxt = (esync[1] && !esync[2]) || (!ST && Emergency);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            pre       <= '0;
            cnt       <= '0;
            TS        <= 1'b0;
            TL        <= 1'b0;
            Emergency <= 1'b0;
            esync     <= '0;
        end else begin
            pre       <= pre_nxt;
            cnt       <= cnt_nxt;
            TS        <= cnt_nxt >= SMIN;
            TL        <= cnt_nxt >= SMAX;
            Emergency <= emerg_nxt;
            esync     <= {esync[1:0], EmergRaw};
        end
    end

    sensor_debounce #(.DEB_LEN(DEB_LEN)) u_car (
        .Clk  (Clk),
        .reset(reset),
        .raw  (CarRaw),
        .level(C)
    );
endmodule

// File: tb/tb_traffic_timer.sv
// tb_traffic_timer: directed plan scenarios plus random traffic, scored against an edge-history model
module tb_traffic_timer;
    localparam int TD  = 4;
    localparam int TSK = 3;
    localparam int TLK = 10;
    localparam int DL  = 3;
    localparam int HN  = 8192;

    typedef struct packed {
        logic ts;
        logic tl;
        logic c;
        logic em;
    } exp_t;

    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic st = 1'b0;
    logic car_raw = 1'b0;
    logic emerg_raw = 1'b0;
    logic ts, tl, c, emergency;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    bit rh[HN];
    bit ch[HN];
    bit eh[HN];
    int e = 0;
    int last = 0;
    bit c_m = 1'b0;
    bit em_m = 1'b0;

    traffic_timer #(
        .TICK_DIV(TD),
        .TS_TICKS(TSK),
        .TL_TICKS(TLK),
        .DEB_LEN (DL),
        .CNT_W   (8)
    ) dut (
        .Clk      (Clk),
        .reset    (rst),
        .ST       (st),
        .CarRaw   (car_raw),
        .EmergRaw (emerg_raw),
        .TS       (ts),
        .TL       (tl),
        .C        (c),
        .Emergency(emergency)
    );

    always #5 Clk = ~Clk;

    // Synchronized level visible after edge x: the raw level sampled one edge earlier
    function automatic bit cs(input int x);
        return (x < 1 || rh[x]) ? 1'b0 : ch[x - 1];
    endfunction

    function automatic bit es(input int x);
        return (x < 1 || rh[x]) ? 1'b0 : eh[x - 1];
    endfunction

    always @(posedge Clk) begin
        bit   flip;
        bit   rise;
        exp_t x;
        rh[e] = rst;
        ch[e] = rst ? 1'b0 : car_raw;
        eh[e] = rst ? 1'b0 : emerg_raw;
        if (rst) begin
            last = e;
            c_m  = 1'b0;
            em_m = 1'b0;
        end else begin
            if (st) last = e;
            flip = e >= DL;
            for (int j = 1; j <= DL; j++)
                if (e >= DL && cs(e - j) == c_m) flip = 1'b0;
            if (flip) c_m = !c_m;
            rise = e >= 2 && es(e - 1) && !es(e - 2);
            em_m = rise ? 1'b1 : st ? 1'b0 : em_m;
        end
        x.ts = (e - last) >= TSK * TD;
        x.tl = (e - last) >= TLK * TD;
        x.c  = c_m;
        x.em = em_m;
        q.push_back(x);
        e++;
    end

    task automatic chk(input string name, input logic got, input logic want);
        if (got !== want) begin
            miscompares++;
            $display("FAIL vec %0d %s got %b want %b", vectors, name, got, want);
        end
    endtask

    always @(negedge Clk) begin
        exp_t x;
        if (q.size() > 0) begin
            x = q.pop_front();
            vectors++;
            chk("TS", ts, x.ts);
            chk("TL", tl, x.tl);
            chk("C", c, x.c);
            chk("Emergency", emergency, x.em);
        end
    end

    task automatic drive(input int n, input bit s, input bit cr, input bit er, input bit r);
        for (int i = 0; i < n; i++) begin
            st        = (i == 0) && s;
            car_raw   = cr;
            emerg_raw = er;
            rst       = r;
            @(negedge Clk);
        end
    endtask

    initial begin
        bit cr = 1'b0;
        bit er = 1'b0;
        drive(2, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0);
        drive(85, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(19, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(70, 0, 0, 0, 0);
        drive(2, 0, 1, 0, 0);
        drive(10, 0, 0, 0, 0);
        drive(20, 0, 1, 0, 0);
        drive(20, 0, 0, 0, 0);
        drive(10, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(20, 0, 0, 1, 0);
        drive(5, 0, 0, 0, 0);
        drive(10, 0, 0, 1, 0);
        drive(5, 0, 0, 0, 0);
        drive(2, 0, 0, 1, 0);
        drive(1, 1, 0, 1, 0);
        drive(5, 0, 0, 1, 0);
        drive(5, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(7, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0);
        drive(20, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0) cr = !cr;
            if ($urandom_range(29) == 0) er = !er;
            drive(1, $urandom_range(24) == 0, cr, er, $urandom_range(399) == 0);
        end
        repeat (3) @(negedge Clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
